// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Instruction-memory request/acknowledge port. The fetch stage
//                is the master (issues req/addr), the memory is the slave
//                (returns ack with rdata valid in the same cycle).
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage with IF/ID pipeline register. Owns the
//                PC, fetches over a req/ack port, absorbs decode stalls in a
//                one-word buffer and drains wrong-path requests after a
//                redirect so the memory address never changes mid-request.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        EN_REG,
    input  wire logic        branch_taken,
    input  wire logic [31:0] branch_target,
    fetch_stage_if.master    imem,
    output logic [31:0]      instruction,
    output logic [31:0]      PCNEXT,
    output logic             block_pipe_instr_cache,
    output logic             flush
);

    localparam logic [31:0] c_PC_STEP    = 32'd4;
    localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;

    // FETCH : request outstanding at pc
    // HAVE  : word parked in r_buf_instr, waiting for decode to accept it
    // DRAIN : wrong-path request at r_drain_addr still outstanding
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HAVE  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_drain_addr;
    logic [31:0] w_drain_addr_nxt;
    logic [31:0] r_buf_instr;
    logic [31:0] w_buf_instr_nxt;
    logic [31:0] r_instruction;
    logic [31:0] w_instruction_nxt;
    logic [31:0] r_pcnext;
    logic [31:0] w_pcnext_nxt;

    logic [31:0] w_pc_inc;
    logic [31:0] w_target;
    logic        w_avail;
    logic [31:0] w_word;

    assign w_pc_inc = r_pc + c_PC_STEP;
    assign w_target = branch_target & c_ALIGN_MASK;
    assign w_avail  = ((r_state == S_FETCH) && imem.ack) || (r_state == S_HAVE);
    assign w_word   = (r_state == S_HAVE) ? r_buf_instr : imem.rdata;

    // State and pipeline register update; reset abandons any outstanding request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_drain_addr  <= 32'd0;
            r_buf_instr   <= 32'd0;
            r_instruction <= NOP_INSTR;
            r_pcnext      <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_drain_addr  <= w_drain_addr_nxt;
            r_buf_instr   <= w_buf_instr_nxt;
            r_instruction <= w_instruction_nxt;
            r_pcnext      <= w_pcnext_nxt;
        end
    end

    // Next-state: a redirect always wins over normal flow, independent of EN_REG
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_drain_addr_nxt  = r_drain_addr;
        w_buf_instr_nxt   = r_buf_instr;
        w_instruction_nxt = r_instruction;
        w_pcnext_nxt      = r_pcnext;

        if (branch_taken) begin
            w_pc_nxt          = w_target;
            w_instruction_nxt = NOP_INSTR;
            w_pcnext_nxt      = 32'd0;
            case (r_state)
                S_FETCH: begin
                    // An unacked request must finish at its original address
                    if (!imem.ack) begin
                        w_drain_addr_nxt = r_pc;
                        w_state_nxt      = S_DRAIN;
                    end
                end
                S_HAVE:  w_state_nxt = S_FETCH;
                S_DRAIN: w_state_nxt = S_DRAIN;
                default: w_state_nxt = S_FETCH;
            endcase
        end else begin
            if (w_avail && EN_REG) begin
                w_instruction_nxt = w_word;
                w_pcnext_nxt      = w_pc_inc;
                w_pc_nxt          = w_pc_inc;
                w_state_nxt       = S_FETCH;
            end else if (!w_avail && EN_REG) begin
                w_instruction_nxt = NOP_INSTR;
                w_pcnext_nxt      = 32'd0;
            end

            if ((r_state == S_FETCH) && imem.ack && !EN_REG) begin
                w_buf_instr_nxt = imem.rdata;
                w_state_nxt     = S_HAVE;
            end

            // Wrong-path data is dropped; the real address goes out next cycle
            if ((r_state == S_DRAIN) && imem.ack) begin
                w_state_nxt = S_FETCH;
            end

            if ((r_state != S_FETCH) && (r_state != S_HAVE) && (r_state != S_DRAIN)) begin
                w_state_nxt = S_FETCH;
            end
        end
    end

    // Memory port and decode-side status; everything quiet while in reset
    always_comb begin
        imem.req               = !reset && ((r_state == S_FETCH) || (r_state == S_DRAIN));
        imem.addr              = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
        block_pipe_instr_cache = !reset && (((r_state == S_FETCH) && !imem.ack) ||
                                            (r_state == S_DRAIN));
        flush                  = branch_taken;
    end

    assign instruction = r_instruction;
    assign PCNEXT      = r_pcnext;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. Expected IF/ID register
//                contents are queued when stimulus is applied and compared
//                after the clock edge that should produce them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcn;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        en;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] instr_o;
    logic [31:0] pcnext_o;
    logic        block_o;
    logic        flush_o;

    logic        reset_w;
    logic        en_w;
    logic        br_w;
    logic [31:0] tgt_w;
    logic [31:0] instr_w;
    logic [31:0] pcnext_w;
    logic        block_w;
    logic        flush_w;

    int n_checks;
    int n_pass;
    exp_t sb[$];
    exp_t sbw[$];
    exp_t e;

    fetch_stage_if imem ();
    fetch_stage_if imem_w ();

    fetch_stage #(.RESET_PC(32'h0000_0100), .NOP_INSTR(32'h0000_0000)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .EN_REG                 (en),
        .branch_taken           (br),
        .branch_target          (tgt),
        .imem                   (imem.master),
        .instruction            (instr_o),
        .PCNEXT                 (pcnext_o),
        .block_pipe_instr_cache (block_o),
        .flush                  (flush_o)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_w (
        .clk                    (clk),
        .reset                  (reset_w),
        .EN_REG                 (en_w),
        .branch_taken           (br_w),
        .branch_target          (tgt_w),
        .imem                   (imem_w.master),
        .instruction            (instr_w),
        .PCNEXT                 (pcnext_w),
        .block_pipe_instr_cache (block_w),
        .flush                  (flush_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1, "watchdog expired");
    end

    // Apply one cycle of stimulus just after a negedge, let comb outputs settle
    task automatic drive(input logic e_i, input logic a_i, input logic b_i,
                         input logic [31:0] t_i, input logic [31:0] d_i);
        en         = e_i;
        imem.ack   = a_i;
        br         = b_i;
        tgt        = t_i;
        imem.rdata = d_i;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h8C22_0004);
        tick();
        tick();
        n_checks++;
        if (imem.req !== 1'b0 || block_o !== 1'b0) $display("FAIL reset_req_block: req=%b block=%b required 0 0", imem.req, block_o);
        else n_pass++;
        n_checks++;
        if (instr_o !== 32'd0 || pcnext_o !== 32'd0) $display("FAIL reset_regs: instr=%h pcnext=%h required 0 0", instr_o, pcnext_o);
        else n_pass++;
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h8C22_0004);
        n_checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h100) $display("FAIL first_req: req=%b addr=%h required 1 00000100", imem.req, imem.addr);
        else n_pass++;
        sb.push_back('{32'h8C22_0004, 32'h104});
        tick();
        e = sb.pop_front();
        n_checks++;
        if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL first_deliver: instr=%h pcnext=%h required %h %h", instr_o, pcnext_o, e.instr, e.pcn);
        else n_pass++;
        n_checks++;
        if (imem.addr !== 32'h104) $display("FAIL next_addr: addr=%h required 00000104", imem.addr);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF);
            n_checks++;
            if (block_o !== 1'b1 || imem.addr !== 32'h104 || imem.req !== 1'b1)
                $display("FAIL wait_block[%0d]: block=%b addr=%h req=%b required 1 00000104 1", i, block_o, imem.addr, imem.req);
            else n_pass++;
            sb.push_back('{32'd0, 32'd0});
            tick();
            e = sb.pop_front();
            n_checks++;
            if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL wait_bubble[%0d]: instr=%h pcnext=%h required %h %h", i, instr_o, pcnext_o, e.instr, e.pcn);
            else n_pass++;
        end
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h1111_1111);
        n_checks++;
        if (block_o !== 1'b0) $display("FAIL wait_ack_block: block=%b required 0", block_o);
        else n_pass++;
        sb.push_back('{32'h1111_1111, 32'h108});
        tick();
        e = sb.pop_front();
        n_checks++;
        if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL wait_deliver: instr=%h pcnext=%h required %h %h", instr_o, pcnext_o, e.instr, e.pcn);
        else n_pass++;
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h2222_2222);
        n_checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h108) $display("FAIL stall_req: req=%b addr=%h required 1 00000108", imem.req, imem.addr);
        else n_pass++;
        sb.push_back('{32'h1111_1111, 32'h108});
        tick();
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            n_checks++;
            if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL stall_hold[%0d]: instr=%h pcnext=%h required %h %h", i, instr_o, pcnext_o, e.instr, e.pcn);
            else n_pass++;
            drive(1'b0, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF);
            n_checks++;
            if (imem.req !== 1'b0 || block_o !== 1'b0) $display("FAIL stall_have[%0d]: req=%b block=%b required 0 0", i, imem.req, block_o);
            else n_pass++;
            sb.push_back('{32'h1111_1111, 32'h108});
            tick();
        end
        e = sb.pop_front();
        n_checks++;
        if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL stall_hold_end: instr=%h pcnext=%h required %h %h", instr_o, pcnext_o, e.instr, e.pcn);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF);
        sb.push_back('{32'h2222_2222, 32'h10C});
        tick();
        e = sb.pop_front();
        n_checks++;
        if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL stall_release: instr=%h pcnext=%h required %h %h", instr_o, pcnext_o, e.instr, e.pcn);
        else n_pass++;
        n_checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h10C) $display("FAIL stall_next_addr: req=%b addr=%h required 1 0000010c", imem.req, imem.addr);
        else n_pass++;
    endtask

    task automatic test_redirect_drain();
        drive(1'b1, 1'b0, 1'b1, 32'h200, 32'hFFFF_FFFF);
        n_checks++;
        if (flush_o !== 1'b1 || imem.addr !== 32'h10C) $display("FAIL redir_flush: flush=%b addr=%h required 1 0000010c", flush_o, imem.addr);
        else n_pass++;
        sb.push_back('{32'd0, 32'd0});
        tick();
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            n_checks++;
            if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL redir_nop[%0d]: instr=%h pcnext=%h required %h %h", i, instr_o, pcnext_o, e.instr, e.pcn);
            else n_pass++;
            drive(1'b1, (i == 2), 1'b0, 32'd0, 32'hDEAD_BEEF);
            n_checks++;
            if (imem.req !== 1'b1 || imem.addr !== 32'h10C || block_o !== 1'b1 || flush_o !== 1'b0)
                $display("FAIL redir_drain[%0d]: req=%b addr=%h block=%b flush=%b required 1 0000010c 1 0", i, imem.req, imem.addr, block_o, flush_o);
            else n_pass++;
            sb.push_back('{32'd0, 32'd0});
            tick();
        end
        e = sb.pop_front();
        n_checks++;
        if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL redir_discard: instr=%h pcnext=%h required %h %h", instr_o, pcnext_o, e.instr, e.pcn);
        else n_pass++;
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h3333_3333);
        n_checks++;
        if (imem.addr !== 32'h200 || imem.req !== 1'b1) $display("FAIL redir_new_addr: addr=%h req=%b required 00000200 1", imem.addr, imem.req);
        else n_pass++;
        sb.push_back('{32'h3333_3333, 32'h204});
        tick();
        e = sb.pop_front();
        n_checks++;
        if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL redir_deliver: instr=%h pcnext=%h required %h %h", instr_o, pcnext_o, e.instr, e.pcn);
        else n_pass++;
    endtask

    task automatic test_branch_with_ack();
        drive(1'b1, 1'b1, 1'b1, 32'h203, 32'h4444_4444);
        n_checks++;
        if (flush_o !== 1'b1 || imem.addr !== 32'h204 || block_o !== 1'b0)
            $display("FAIL brack_cycle: flush=%b addr=%h block=%b required 1 00000204 0", flush_o, imem.addr, block_o);
        else n_pass++;
        sb.push_back('{32'd0, 32'd0});
        tick();
        e = sb.pop_front();
        n_checks++;
        if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL brack_discard: instr=%h pcnext=%h required %h %h", instr_o, pcnext_o, e.instr, e.pcn);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF);
        n_checks++;
        if (imem.addr !== 32'h200 || imem.req !== 1'b1) $display("FAIL brack_no_drain: addr=%h req=%b required 00000200 1", imem.addr, imem.req);
        else n_pass++;
        sb.push_back('{32'd0, 32'd0});
        tick();
        e = sb.pop_front();
        n_checks++;
        if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL brack_bubble: instr=%h pcnext=%h required %h %h", instr_o, pcnext_o, e.instr, e.pcn);
        else n_pass++;
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h5555_5555);
        sb.push_back('{32'h5555_5555, 32'h204});
        tick();
        e = sb.pop_front();
        n_checks++;
        if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL brack_deliver: instr=%h pcnext=%h required %h %h", instr_o, pcnext_o, e.instr, e.pcn);
        else n_pass++;
    endtask

    task automatic test_branch_from_have();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h6666_6666);
        sb.push_back('{32'h5555_5555, 32'h204});
        tick();
        e = sb.pop_front();
        n_checks++;
        if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL have_hold: instr=%h pcnext=%h required %h %h", instr_o, pcnext_o, e.instr, e.pcn);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b1, 32'h300, 32'hFFFF_FFFF);
        n_checks++;
        if (flush_o !== 1'b1 || imem.req !== 1'b0) $display("FAIL have_branch: flush=%b req=%b required 1 0", flush_o, imem.req);
        else n_pass++;
        sb.push_back('{32'd0, 32'd0});
        tick();
        e = sb.pop_front();
        n_checks++;
        if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL have_flush_nop: instr=%h pcnext=%h required %h %h", instr_o, pcnext_o, e.instr, e.pcn);
        else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF);
        n_checks++;
        if (imem.req !== 1'b1 || imem.addr !== 32'h300 || block_o !== 1'b1)
            $display("FAIL have_refetch: req=%b addr=%h block=%b required 1 00000300 1", imem.req, imem.addr, block_o);
        else n_pass++;
        sb.push_back('{32'd0, 32'd0});
        tick();
        e = sb.pop_front();
        n_checks++;
        if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL have_bubble: instr=%h pcnext=%h required %h %h", instr_o, pcnext_o, e.instr, e.pcn);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        logic [31:0] word;
        exp_pc = 32'h300;
        for (int i = 0; i < 6; i++) begin
            word = $urandom;
            drive(1'b1, 1'b1, 1'b0, 32'd0, word);
            n_checks++;
            if (imem.addr !== exp_pc || block_o !== 1'b0) $display("FAIL b2b_addr[%0d]: addr=%h block=%b required %h 0", i, imem.addr, block_o, exp_pc);
            else n_pass++;
            sb.push_back('{word, exp_pc + 32'd4});
            exp_pc = exp_pc + 32'd4;
            tick();
            e = sb.pop_front();
            n_checks++;
            if (instr_o !== e.instr || pcnext_o !== e.pcn) $display("FAIL b2b_deliver[%0d]: instr=%h pcnext=%h required %h %h", i, instr_o, pcnext_o, e.instr, e.pcn);
            else n_pass++;
        end
    endtask

    task automatic test_pc_wrap();
        reset_w = 1'b0;
        #1;
        n_checks++;
        if (imem_w.addr !== 32'hFFFF_FFFC || imem_w.req !== 1'b1) $display("FAIL wrap_first_addr: addr=%h req=%b required fffffffc 1", imem_w.addr, imem_w.req);
        else n_pass++;
        sbw.push_back('{32'hA5A5_5A5A, 32'h0});
        tick();
        e = sbw.pop_front();
        n_checks++;
        if (instr_w !== e.instr || pcnext_w !== e.pcn) $display("FAIL wrap_deliver: instr=%h pcnext=%h required %h %h", instr_w, pcnext_w, e.instr, e.pcn);
        else n_pass++;
        n_checks++;
        if (imem_w.addr !== 32'h0) $display("FAIL wrap_next_addr: addr=%h required 00000000", imem_w.addr);
        else n_pass++;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        reset_w      = 1'b1;
        en_w         = 1'b1;
        br_w         = 1'b0;
        tgt_w        = 32'd0;
        imem_w.ack   = 1'b1;
        imem_w.rdata = 32'hA5A5_5A5A;
        test_reset();
        test_wait_states();
        test_stall();
        test_redirect_drain();
        test_branch_with_ack();
        test_branch_from_have();
        test_back_to_back();
        test_pc_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register. It owns the program counter, fetches instructions over a req/ack instruction-memory port, and presents `instruction`, `PCNEXT` and `block_pipe_instr_cache` to the decode stage. It accepts taken-branch redirects from the execute stage and drives the decode-stage `flush`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `NOP_INSTR`, default 32'h0000_0000: encoding loaded into `instruction` for bubbles and flushes.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `EN_REG`  in  1  IF/ID register enable; comes from decode control `EN_REG_FETCH`.
- `branch_taken`  in  1  one-cycle redirect request.
- `branch_target`  in  32  redirect PC; bits [1:0] are forced to 0 internally.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1 and `imem_ack`=0.
- `imem_ack`  in  1  request complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instruction`  out  32  IF/ID register: instruction to decode.
- `PCNEXT`  out  32  IF/ID register: PC+4 of `instruction`.
- `block_pipe_instr_cache`  out  1  no instruction available this cycle.
- `flush`  out  1  clears the decode stage register; combinational, equals `branch_taken`.

## Operation
- Registers: `pc`, `drain_addr`, `buf_instr`, 2-bit `state`, plus the `instruction` and `PCNEXT` outputs.
- States:
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - HAVE: fetched word held in `buf_instr`; `imem_req`=0.
  - DRAIN: wrong-path request still outstanding; `imem_req`=1, `imem_addr`=`drain_addr`.
- "Available" means (FETCH and `imem_ack`=1) or HAVE. The word is `imem_rdata` in FETCH and `buf_instr` in HAVE.
- `block_pipe_instr_cache` = (FETCH and not `imem_ack`) or DRAIN. It is 0 while `reset`=1.
- Priority order, highest first: `reset`, `branch_taken`, normal flow.
- Redirect (`branch_taken`=1), regardless of `EN_REG`:
  - `pc` <= {`branch_target`[31:2], 2'b00}; `instruction` <= `NOP_INSTR`; `PCNEXT` <= 0.
  - From FETCH without ack: `drain_addr` <= current `pc`, go to DRAIN.
  - From FETCH with ack: discard `imem_rdata`, stay in FETCH.
  - From HAVE: discard the buffer, go to FETCH.
  - From DRAIN: stay in DRAIN; `drain_addr` is unchanged.
- Normal flow:
  - Available and `EN_REG`=1: `instruction` <= word; `PCNEXT` <= `pc`+4; `pc` <= `pc`+4; go to FETCH.
  - FETCH with ack and `EN_REG`=0: `buf_instr` <= `imem_rdata`, go to HAVE; `pc` holds.
  - HAVE and `EN_REG`=0: hold all state.
  - Not available and `EN_REG`=1: `instruction` <= `NOP_INSTR`, `PCNEXT` <= 0 (bubble).
  - Not available and `EN_REG`=0: hold.
  - DRAIN and `imem_ack`=1: discard the data, go to FETCH (the new address is issued next cycle).
- Arithmetic: `pc`+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values: `pc`=`RESET_PC`, `state`=FETCH, `instruction`=`NOP_INSTR`, `PCNEXT`=0, `buf_instr`=0, `drain_addr`=0.
- While `reset`=1, `imem_req`=0 and `block_pipe_instr_cache`=0. `imem_req` rises in the first cycle after reset deasserts.
- Reset during an outstanding request abandons it; the memory side shares `reset` and drops the request.
- Zero-wait memory: one instruction per cycle. The ack at cycle t reaches `instruction` at t+1, and the next address is issued at t+1.
- N wait cycles produce N cycles of `block_pipe_instr_cache`=1 and N bubbles when `EN_REG`=1.
- `imem_addr` never changes while a request is unacked, including across redirects (DRAIN guarantees this).
- `flush` is asserted in the same cycle as `branch_taken`, so decode clears its register at the same edge that `instruction` becomes `NOP_INSTR`.
- HAVE to delivery: one cycle after `EN_REG` rises.

## Test plan
- Reset with `RESET_PC`=0x100, zero-wait ack, `imem_rdata`=0x8C220004, `EN_REG`=1 -> next cycle `instruction`=0x8C220004, `PCNEXT`=0x104, `imem_addr`=0x104; `imem_req` is 0 during reset.
- Ack delayed 3 cycles at address 0x104 -> `block_pipe_instr_cache`=1 for 3 cycles, `instruction`=0 for 3 cycles, `imem_addr` held at 0x104, then delivery with `PCNEXT`=0x108.
- `EN_REG`=0 at ack of 0x108 -> HAVE, `imem_req`=0, block=0; `EN_REG` rises 2 cycles later -> word delivered next cycle, then `imem_addr`=0x10C.
- Request to 0x10C unacked, `branch_taken`=1, target 0x200 -> `flush`=1 that cycle, `instruction`=0, `imem_addr` stays 0x10C until ack, data discarded, next `imem_addr`=0x200.
- `branch_taken` with target 0x203 in the same cycle as an ack -> data discarded, next `imem_addr`=0x200, no DRAIN.
- `RESET_PC`=0xFFFF_FFFC, zero-wait ack -> `PCNEXT`=0, next `imem_addr`=0.
